// File: rtl/axis_header_sched_pkg.sv
// axis_hdr_pkg: shared FSM state type and end-of-packet helper for the header scheduler
package axis_hdr_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, WAIT_EOP = 2'd2} state_e;
  function automatic logic eop(input logic valid, input logic ready, input logic last);
    return valid & ready & last;
  endfunction
endpackage

// File: rtl/axis_header_sched_if.sv
// axis_header_sched_if: header-insert channel between the scheduler and the inserter
interface axis_header_sched_if #(
  parameter int DATA_WD = 32,
  localparam int DATA_BYTE_WD = DATA_WD / 8,
  localparam int BYTE_CNT_WD = $clog2(DATA_BYTE_WD)
);
  logic                    valid_insert;
  logic [DATA_WD-1:0]      header_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD:0]    byte_insert_cnt;
  logic                    ready_insert;
  modport master (output valid_insert, header_insert, keep_insert, byte_insert_cnt, input ready_insert);
  modport slave (input valid_insert, header_insert, keep_insert, byte_insert_cnt, output ready_insert);
endinterface

// File: rtl/axis_header_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i with wraparound
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);
  logic [IW-1:0] j;
  // scanning from the farthest offset down lets the nearest requester overwrite earlier hits
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N_REQ);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axis_header_sched.sv
// axis_header_sched: round-robin owner of the header-insert channel, held until the packet's last beat
module axis_header_sched
  import axis_hdr_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_WD = 32,
  parameter int TIMEOUT = 1024,
  parameter int PKT_CNT_WD = 16,
  localparam int DATA_BYTE_WD = DATA_WD / 8,
  localparam int BYTE_CNT_WD = $clog2(DATA_BYTE_WD),
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ*DATA_WD-1:0]         req_header,
  input  logic [N_REQ*DATA_BYTE_WD-1:0]    req_keep,
  input  logic [N_REQ*(BYTE_CNT_WD+1)-1:0] req_byte_cnt,
  output logic [N_REQ-1:0]                 req_ready,
  axis_header_sched_if.master              ins,
  input  logic                             mon_valid_out,
  input  logic                             mon_ready_out,
  input  logic                             mon_last_out,
  output logic [IW-1:0]                    grant_id,
  output logic                             busy,
  output logic                             timeout_err,
  output logic [PKT_CNT_WD-1:0]            pkt_cnt
);
  localparam int WDW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_e                  state_q, state_d;
  logic [IW-1:0]           rr_q, grant_q, win_idx;
  logic [N_REQ-1:0]        win_gnt;
  logic                    win_any, eop_w, to_hit, take;
  logic [DATA_WD-1:0]      header_q;
  logic [DATA_BYTE_WD-1:0] keep_q;
  logic [BYTE_CNT_WD:0]    cnt_q;
  logic [WDW-1:0]          wd_q;
  logic                    terr_q;
  logic [PKT_CNT_WD-1:0]   pkt_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i(req_valid),
    .ptr_i(rr_q),
    .gnt_o(win_gnt),
    .idx_o(win_idx),
    .any_o(win_any)
  );

  // no accept strobe while reset is held, so a source never drops a header the FSM discards
  always_comb begin
    eop_w = eop(mon_valid_out, mon_ready_out, mon_last_out);
    to_hit = TIMEOUT != 0 && int'(wd_q) == TIMEOUT - 1;
    take = state_q == IDLE && win_any && !rst;
    state_d = take ? OFFER :
              (state_q == OFFER && ins.ready_insert) ? WAIT_EOP :
              (state_q == WAIT_EOP && (eop_w || to_hit)) ? IDLE : state_q;
  end

  assign req_ready           = take ? win_gnt : '0;
  assign ins.valid_insert    = state_q == OFFER;
  assign ins.header_insert   = header_q;
  assign ins.keep_insert     = keep_q;
  assign ins.byte_insert_cnt = cnt_q;
  assign grant_id            = grant_q;
  assign busy                = state_q != IDLE;
  assign timeout_err         = terr_q;
  assign pkt_cnt             = pkt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      header_q <= '0;
      keep_q   <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      terr_q   <= 1'b0;
      pkt_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= state_q == WAIT_EOP ? wd_q + 1'b1 : '0;
      terr_q  <= state_q == WAIT_EOP && !eop_w && to_hit;
      if (state_q == WAIT_EOP && eop_w) pkt_q <= pkt_q + 1'b1;
      if (take) begin
        header_q <= req_header[win_idx*DATA_WD +: DATA_WD];
        keep_q   <= req_keep[win_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
        cnt_q    <= req_byte_cnt[win_idx*(BYTE_CNT_WD+1) +: BYTE_CNT_WD+1];
        grant_q  <= win_idx;
        rr_q     <= win_idx == IW'(N_REQ - 1) ? '0 : win_idx + 1'b1;
      end
    end
  end
endmodule
